// File: rtl/imm_pkg.sv
// Shared immediate-format definitions: format select encoding and the instruction
// bit positions of each immediate field, common to the encoder and the core's sign extender.
package imm_pkg;

    typedef enum logic [1:0] {
        IMM_S    = 2'b00,
        IMM_I    = 2'b01,
        IMM_B    = 2'b10,
        IMM_RSVD = 2'b11
    } imm_src_e;

    localparam int INSTR_W = 32;

    // S-type: imm[11:5] high field, imm[4:0] low field
    localparam int S_HI_MSB = 31;
    localparam int S_HI_LSB = 25;
    localparam int S_LO_MSB = 11;
    localparam int S_LO_LSB = 7;

    // I-type: imm[11:0]
    localparam int I_MSB = 31;
    localparam int I_LSB = 20;

    // B-type: imm[12], imm[10:5], imm[4:1], imm[11]
    localparam int B_SIGN   = 31;
    localparam int B_HI_MSB = 30;
    localparam int B_HI_LSB = 25;
    localparam int B_LO_MSB = 11;
    localparam int B_LO_LSB = 8;
    localparam int B_BIT11  = 7;

endpackage

// File: rtl/imm_pack.sv
// Combinational immediate packer: scatters a sign-extended immediate into S/I/B field slots.
// Optional range check enabled by defining IMM_RANGE_CHECK_EN.
module imm_pack
    import imm_pkg::*;
(
    input  logic [INSTR_W-1:0] i_base,
    input  logic [31:0]        i_imm,
    input  logic [1:0]         i_src,
    output logic [INSTR_W-1:0] o_instr,
    output logic               o_range_err
);

    logic [INSTR_W-1:0] w_field;

    always_comb begin
        w_field = '0;
        case (imm_src_e'(i_src))
            IMM_S: begin
                w_field[S_HI_MSB:S_HI_LSB] = i_imm[11:5];
                w_field[S_LO_MSB:S_LO_LSB] = i_imm[4:0];
            end
            IMM_I: begin
                w_field[I_MSB:I_LSB] = i_imm[11:0];
            end
            IMM_B: begin
                w_field[B_SIGN]            = i_imm[12];
                w_field[B_HI_MSB:B_HI_LSB] = i_imm[10:5];
                w_field[B_LO_MSB:B_LO_LSB] = i_imm[4:1];
                w_field[B_BIT11]           = i_imm[11];
            end
            default: w_field = '0;
        endcase
    end

    assign o_instr = i_base | w_field;

`ifdef IMM_RANGE_CHECK_EN
    logic w_fit12;
    logic w_fit13;

    // A value fits when every bit above the field's sign bit copies that sign bit
    assign w_fit12 = (&i_imm[31:11]) | ~(|i_imm[31:11]);
    assign w_fit13 = ((&i_imm[31:12]) | ~(|i_imm[31:12])) & ~i_imm[0];

    always_comb begin
        o_range_err = 1'b0;
        case (imm_src_e'(i_src))
            IMM_S, IMM_I: o_range_err = ~w_fit12;
            IMM_B:        o_range_err = ~w_fit13;
            default:      o_range_err = 1'b0;
        endcase
    end
`else
    logic w_unused_imm;

    assign w_unused_imm = ^{i_imm[31:13], i_imm[0]};
    assign o_range_err  = 1'b0;
`endif

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder: packs requests via imm_pack into a 2-entry output FIFO with a
// word-address counter and sticky error flag. Optional range check: IMM_RANGE_CHECK_EN.
module imm_encoder
    import imm_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           base_instr,
    input  logic [31:0]           imm,
    input  logic [1:0]            imm_src,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_instr,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  err,
    input  logic                  err_clr
);

    logic [31:0]           r_mem [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_err;
    logic                  r_active;

    logic [31:0]           w_instr;
    logic                  w_range_err;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_accept;
    logic                  w_drop;
    logic                  w_push;
    logic                  w_pop;

    imm_pack u_pack (
        .i_base      (base_instr),
        .i_imm       (imm),
        .i_src       (imm_src),
        .o_instr     (w_instr),
        .o_range_err (w_range_err)
    );

    assign w_full   = (r_count == 2'd2);
    assign w_empty  = (r_count == 2'd0);
    // r_active holds in_ready low until the first clock after reset release
    assign in_ready = r_active & ~w_full;
    assign w_accept = in_valid & in_ready;
    assign w_drop   = (imm_src_e'(imm_src) == IMM_RSVD) | w_range_err;
    assign w_push   = w_accept & ~w_drop;
    assign w_pop    = ~w_empty & out_ready;

    assign out_valid = ~w_empty;
    assign out_instr = w_empty ? 32'd0 : r_mem[r_rd_ptr];
    assign out_addr  = r_addr;
    assign err       = r_err;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_instr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_addr   <= BASE_ADDR;
            r_err    <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_active <= 1'b1;
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
                r_addr   <= r_addr + 1'b1;
            end
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
            // A new error on the same cycle as err_clr keeps the flag set
            if (w_accept && w_drop) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed self-checking bench for imm_encoder: table-driven packing vectors plus
// hand-written backpressure, error, range, wrap and reset sequences.
module tb_imm_encoder;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   base_instr;
    logic [31:0]   imm;
    logic [1:0]    imm_src;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [AW-1:0] out_addr;
    logic          err;
    logic          err_clr;

    int checks = 0;
    int errors = 0;
    logic [AW-1:0] exp_addr;

    imm_encoder #(.ADDR_WIDTH(AW), .BASE_ADDR('0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .base_instr (base_instr),
        .imm        (imm),
        .imm_src    (imm_src),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_addr   (out_addr),
        .err        (err),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] base;
        logic [31:0] imm;
        logic [1:0]  src;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{32'h0000_0013, 32'hFFFF_FFFF, 2'b01, 32'hFFF0_0013};
        vecs[1] = '{32'h0000_2023, 32'h0000_07FF, 2'b00, 32'h7E00_2FA3};
        vecs[2] = '{32'h0000_0063, 32'hFFFF_FFFC, 2'b10, 32'hFE00_0EE3};
        vecs[3] = '{32'h0000_2023, 32'hFFFF_F800, 2'b00, 32'h8000_2023};
        vecs[4] = '{32'h0000_0063, 32'h0000_0FFE, 2'b10, 32'h7E00_0FE3};

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        base_instr = '0;
        imm        = '0;
        imm_src    = 2'b00;
        out_ready  = 1'b0;
        err_clr    = 1'b0;

        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_addr", {30'd0, out_addr}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        exp_addr = '0;

        // Backpressure: two accepted, third stalls while full
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        base_instr = 32'h0000_0013;
        imm_src    = 2'b01;
        imm        = 32'd1;
        tick();
        imm = 32'd2;
        chk("bp_ready_second", {31'd0, in_ready}, 32'd1);
        tick();
        imm = 32'd3;
        chk("bp_ready_full", {31'd0, in_ready}, 32'd0);
        chk("bp_head_a", out_instr, 32'h0010_0013);
        tick();
        chk("bp_head_a_stable", out_instr, 32'h0010_0013);
        chk("bp_addr_a", {30'd0, out_addr}, 32'd0);
        out_ready = 1'b1;
        chk("bp_ready_full_outrdy", {31'd0, in_ready}, 32'd0);
        tick();
        chk("bp_head_b", out_instr, 32'h0020_0013);
        chk("bp_addr_b", {30'd0, out_addr}, 32'd1);
        chk("bp_ready_after_pop", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_head_c_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_head_c", out_instr, 32'h0030_0013);
        chk("bp_addr_c", {30'd0, out_addr}, 32'd2);
        tick();
        chk("bp_drained", {31'd0, out_valid}, 32'd0);
        exp_addr = 2'd3;

        // Packing vectors; addresses run 3,0,1,2,3 across the wrap
        for (int i = 0; i < 5; i++) begin
            base_instr = vecs[i].base;
            imm        = vecs[i].imm;
            imm_src    = vecs[i].src;
            in_valid   = 1'b1;
            tick();
            in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("vec%0d_instr", i), out_instr, vecs[i].exp);
            chk($sformatf("vec%0d_addr", i), {30'd0, out_addr}, {30'd0, exp_addr});
            tick();
            exp_addr = exp_addr + 1'b1;
            chk($sformatf("vec%0d_popped", i), {31'd0, out_valid}, 32'd0);
        end

        // Reserved format: dropped, sticky err, set wins over clear
        base_instr = 32'h0000_0013;
        imm        = 32'd5;
        imm_src    = 2'b11;
        in_valid   = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("rsvd_err", {31'd0, err}, 32'd1);
        chk("rsvd_no_valid", {31'd0, out_valid}, 32'd0);
        chk("rsvd_addr", {30'd0, out_addr}, {30'd0, exp_addr});
        in_valid = 1'b1;
        err_clr  = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("rsvd_set_wins", {31'd0, err}, 32'd1);
        tick();
        err_clr = 1'b0;
        chk("err_cleared", {31'd0, err}, 32'd0);

        // Range boundaries: I imm 0x800, B odd imm
        base_instr = 32'h0000_0013;
        imm        = 32'h0000_0800;
        imm_src    = 2'b01;
        in_valid   = 1'b1;
        tick();
        in_valid = 1'b0;
`ifdef IMM_RANGE_CHECK_EN
        chk("range_i_err", {31'd0, err}, 32'd1);
        chk("range_i_no_valid", {31'd0, out_valid}, 32'd0);
        chk("range_i_addr", {30'd0, out_addr}, {30'd0, exp_addr});
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("range_i_clr", {31'd0, err}, 32'd0);
`else
        chk("trunc_i_err", {31'd0, err}, 32'd0);
        chk("trunc_i_valid", {31'd0, out_valid}, 32'd1);
        chk("trunc_i_instr", out_instr, 32'h8000_0013);
        tick();
        exp_addr = exp_addr + 1'b1;
`endif
        base_instr = 32'h0000_0063;
        imm        = 32'hFFFF_FFFD;
        imm_src    = 2'b10;
        in_valid   = 1'b1;
        tick();
        in_valid = 1'b0;
`ifdef IMM_RANGE_CHECK_EN
        chk("range_b_err", {31'd0, err}, 32'd1);
        chk("range_b_no_valid", {31'd0, out_valid}, 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
`else
        chk("trunc_b_err", {31'd0, err}, 32'd0);
        chk("trunc_b_instr", out_instr, 32'hFE00_0EE3);
        chk("trunc_b_addr", {30'd0, out_addr}, {30'd0, exp_addr});
        tick();
        exp_addr = exp_addr + 1'b1;
`endif

        // Reset with two words queued
        out_ready  = 1'b0;
        base_instr = 32'h0000_0013;
        imm_src    = 2'b01;
        imm        = 32'd7;
        in_valid   = 1'b1;
        tick();
        imm = 32'd8;
        tick();
        in_valid = 1'b0;
        chk("mid_queued_valid", {31'd0, out_valid}, 32'd1);
        chk("mid_queued_addr", {30'd0, out_addr}, {30'd0, exp_addr});
        out_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_addr", {30'd0, out_addr}, 32'd0);
        chk("mid_rst_instr", out_instr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("mid_rel_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rel_empty", {31'd0, out_valid}, 32'd0);
        chk("mid_rel_addr", {30'd0, out_addr}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 Parameter ADDR_WIDTH, default 12: width of the instruction-memory word address counter.
REQ-002 Parameter BASE_ADDR, default 0: word address loaded into the counter at reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  encode request present.
REQ-006 in_ready  output  1  encoder can accept a request this cycle.
REQ-007 base_instr  input  32  instruction with all immediate bit positions zero; opcode, funct and register fields populated.
REQ-008 imm  input  32  sign-extended immediate value to pack.
REQ-009 imm_src  input  2  format select: 00 S-type, 01 I-type, 10 B-type, 11 reserved.
REQ-010 out_valid  output  1  encoded word available.
REQ-011 out_ready  input  1  instruction-memory writer accepts the word.
REQ-012 out_instr  output  32  encoded instruction.
REQ-013 out_addr  output  ADDR_WIDTH  word address for out_instr.
REQ-014 err  output  1  sticky encode-error flag.
REQ-015 err_clr  input  1  synchronous clear of err.

Function
REQ-016 Packing SHALL be the exact inverse of the core's immediate extension: S: [31:25]=imm[11:5], [11:7]=imm[4:0]; I: [31:20]=imm[11:0]; B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]; fields OR-ed into base_instr.
REQ-017 Request accepted on a cycle with in_valid and in_ready both high; accepted word pushed into a 2-entry output FIFO.
REQ-018 Latency: accepted word SHALL appear on out_instr with out_valid high on the cycle after acceptance (no same-cycle bypass).
REQ-019 in_ready SHALL equal FIFO-not-full; when full, in_ready is low even if out_ready is high that cycle.
REQ-020 out_valid SHALL equal FIFO-not-empty; out_instr/out_addr are stable while out_valid high and out_ready low.
REQ-021 Address counter SHALL increment by one on each output handshake; wraps from 2^ADDR_WIDTH-1 to 0 with no flag.
REQ-022 out_addr SHALL equal current counter value while head word is presented.
REQ-023 Simultaneous push and pop with one entry held SHALL keep occupancy at one and preserve order.
REQ-024 imm_src 11 on acceptance SHALL set err and drop the request (no push, counter unchanged).
REQ-025 err_clr and a same-cycle error event: the set SHALL win.

Reset
REQ-026 rst_n low SHALL asynchronously empty the FIFO, drive out_valid 0, in_ready 1 (from the cycle after release), err 0, counter BASE_ADDR, out_instr 0.
REQ-027 Reset asserted mid-transfer SHALL discard all queued words; no handshake completes in a reset cycle.

Configuration
REQ-028 Macro IMM_RANGE_CHECK_EN defined: request SHALL be dropped and err set when imm is unrepresentable (I/S: imm[31:11] not all equal; B: imm[0]=1 or imm[31:12] not all equal).
REQ-029 Macro undefined: no range check; upper imm bits silently truncated, imm[0] ignored for B; err set only per REQ-024.

Structure
REQ-030 Package imm_pkg SHALL hold the imm_src encoding enum (IMM_S, IMM_I, IMM_B, IMM_RSVD) and the field bit-position constants, shared with the core's sign extender.
REQ-031 Combinational packing and range check SHALL live in sub-module imm_pack; FIFO, counter and err in imm_encoder.

Verification
REQ-032 I-type: base 0x00000013, imm 0xFFFFFFFF, out_ready 1 -> next cycle out_instr 0xFFF00013, out_addr 0.
REQ-033 S-type: base 0x00002023, imm 0x000007FF -> out_instr 0x7E002FA3.
REQ-034 B-type: base 0x00000063, imm 0xFFFFFFFC -> out_instr 0xFE000EE3.
REQ-035 Backpressure: out_ready 0, three back-to-back requests -> two accepted, in_ready 0 on third; release -> words in order, addresses 0,1, then third accepted.
REQ-036 Range (macro on): I-type imm 0x00000800 -> err 1, no out_valid, counter unchanged; err_clr -> err 0; macro off -> out_instr bits[31:20] 0x800.
REQ-037 Wrap and reset: ADDR_WIDTH 2, five words -> addresses 0,1,2,3,0; rst_n low with two queued -> out_valid 0 immediately, counter 0.
